// File: rtl/lu_cache_arbiter.sv
// Round-robin arbiter sharing the LU cache write port between REQ_COUNT requesters.
// Each grant issues one write strobe, then waits a settle period before acking the requester.
module lu_cache_arbiter #(
  parameter int unsigned REQ_COUNT     = 4,
  parameter int unsigned CELL_SIZE     = 8,
  parameter int unsigned CELL_COUNT    = 8,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [REQ_COUNT-1:0]             req,
  input  logic [REQ_COUNT*CELL_SIZE-1:0]   req_data,
  output logic [REQ_COUNT-1:0]             ack,
  output logic                             ack_hit,
  input  logic [CELL_COUNT*CELL_SIZE-1:0]  cache_data_out,
  output logic [CELL_SIZE-1:0]             cache_data_in,
  output logic                             cache_new_data,
  output logic                             busy
);

  localparam int unsigned IdxW = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;
  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StSettle} state_e;

  state_e                 state_q;
  logic [CntW-1:0]        cnt_q;
  logic [IdxW-1:0]        last_q;
  logic [IdxW-1:0]        grant_q;
  logic                   hit_q;
  logic [REQ_COUNT-1:0]   ack_q;
  logic                   ack_hit_q;
  logic [CELL_SIZE-1:0]   data_q;
  logic                   new_q;
  logic                   busy_q;

  logic                   hi_v, lo_v;
  logic [IdxW-1:0]        hi_idx, lo_idx;
  logic                   pick_valid;
  logic [IdxW-1:0]        pick_idx;
  logic [CELL_SIZE-1:0]   pick_word;
  logic                   pick_hit;

  // Requesters above the last grant win first; otherwise wrap to the lowest index.
  always_comb begin
    hi_v   = 1'b0;
    lo_v   = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = 0; i < int'(REQ_COUNT); i++) begin
      if (req[i]) begin
        if (i > int'(last_q)) begin
          if (!hi_v) begin
            hi_v   = 1'b1;
            hi_idx = IdxW'(i);
          end
        end else if (!lo_v) begin
          lo_v   = 1'b1;
          lo_idx = IdxW'(i);
        end
      end
    end
    pick_valid = hi_v | lo_v;
    pick_idx   = hi_v ? hi_idx : lo_idx;
  end

  // No per-cell valid bits: a cleared cell matches a zero word.
  always_comb begin
    pick_word = '0;
    for (int i = 0; i < int'(REQ_COUNT); i++) begin
      if (pick_idx == IdxW'(i)) begin
        pick_word = req_data[i*CELL_SIZE +: CELL_SIZE];
      end
    end
    pick_hit = 1'b0;
    for (int k = 0; k < int'(CELL_COUNT); k++) begin
      if (cache_data_out[k*CELL_SIZE +: CELL_SIZE] == pick_word) begin
        pick_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      last_q    <= IdxW'(REQ_COUNT - 1);
      grant_q   <= '0;
      hit_q     <= 1'b0;
      ack_q     <= '0;
      ack_hit_q <= 1'b0;
      data_q    <= '0;
      new_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      new_q     <= 1'b0;
      ack_q     <= '0;
      ack_hit_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            grant_q <= pick_idx;
            last_q  <= pick_idx;
            data_q  <= pick_word;
            hit_q   <= pick_hit;
            new_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          state_q <= StSettle;
          cnt_q   <= '0;
          if (SETTLE_CYCLES == 1) begin
            ack_q     <= REQ_COUNT'(1) << grant_q;
            ack_hit_q <= hit_q;
          end
        end
        StSettle: begin
          if (cnt_q == CntLast) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
            // Ack is registered, so raise it on entry to the final settle cycle.
            if (cnt_q + CntW'(1) == CntLast) begin
              ack_q     <= REQ_COUNT'(1) << grant_q;
              ack_hit_q <= hit_q;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ack            = ack_q;
  assign ack_hit        = ack_hit_q;
  assign cache_data_in  = data_q;
  assign cache_new_data = new_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_lu_cache_arbiter.sv
// Scoreboard bench for lu_cache_arbiter: expected writes/acks queued at stimulus time.
module tb_lu_cache_arbiter;

  localparam int RC = 4;
  localparam int CS = 8;
  localparam int CC = 8;
  localparam int SC = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [RC-1:0]     req;
  logic [RC*CS-1:0]  req_data;
  logic [CC*CS-1:0]  cache_data_out;
  logic [RC-1:0]     ack;
  logic              ack_hit;
  logic [CS-1:0]     cache_data_in;
  logic              cache_new_data;
  logic              busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          idx;
    logic [CS-1:0] data;
    logic        hit;
  } txn_t;

  txn_t wr_q[$];
  txn_t ack_q[$];

  always #5 clk = ~clk;

  lu_cache_arbiter #(
    .REQ_COUNT    (RC),
    .CELL_SIZE    (CS),
    .CELL_COUNT   (CC),
    .SETTLE_CYCLES(SC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_data      (req_data),
    .ack           (ack),
    .ack_hit       (ack_hit),
    .cache_data_out(cache_data_out),
    .cache_data_in (cache_data_in),
    .cache_new_data(cache_new_data),
    .busy          (busy)
  );

  task automatic push_txn(input int idx, input logic [CS-1:0] data, input logic hit);
    txn_t t;
    t.idx  = idx;
    t.data = data;
    t.hit  = hit;
    wr_q.push_back(t);
    ack_q.push_back(t);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req   = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset          = 1'b0;
    req            = '0;
    req_data       = '0;
    cache_data_out = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (ack !== 4'b0) begin
      n_bad++; $display("FAIL reset_ack: got %b want 0000", ack);
    end
    n_cmp++;
    if (ack_hit !== 1'b0) begin
      n_bad++; $display("FAIL reset_ack_hit: got %b want 0", ack_hit);
    end
    n_cmp++;
    if (cache_data_in !== 8'd0) begin
      n_bad++; $display("FAIL reset_data_in: got %0d want 0", cache_data_in);
    end
    n_cmp++;
    if (cache_new_data !== 1'b0) begin
      n_bad++; $display("FAIL reset_new_data: got %b want 0", cache_new_data);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    reset = 1'b1;
  endtask

  task automatic test_single();
    logic          exp_new;
    logic          exp_busy;
    logic [RC-1:0] exp_ack;
    req_data        = '0;
    req_data[15:8]  = 8'd9;
    req[1]          = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      exp_new  = (k == 1);
      exp_ack  = (k == 3) ? 4'b0010 : 4'b0000;
      exp_busy = (k <= 3);
      n_cmp++;
      if (cache_new_data !== exp_new || ack !== exp_ack || ack_hit !== 1'b0 ||
          busy !== exp_busy || cache_data_in !== 8'd9) begin
        n_bad++;
        $display("FAIL single_cycle%0d: new=%b ack=%b hit=%b busy=%b din=%0d want new=%b ack=%b hit=0 busy=%b din=9",
                 k, cache_new_data, ack, ack_hit, busy, cache_data_in, exp_new, exp_ack, exp_busy);
      end
      if (ack[1] === 1'b1) req[1] = 1'b0;
    end
    req = '0;
  endtask

  task automatic test_all_four();
    txn_t          t;
    int            last_c;
    logic [RC-1:0] prev_ack;
    do_reset();
    req_data = {8'd5, 8'd4, 8'd2, 8'd1};
    push_txn(0, 8'd1, 1'b0);
    push_txn(1, 8'd2, 1'b0);
    push_txn(2, 8'd4, 1'b0);
    push_txn(3, 8'd5, 1'b0);
    req      = 4'b1111;
    last_c   = -1;
    prev_ack = '0;
    for (int c = 0; c < 80 && (wr_q.size() != 0 || ack_q.size() != 0); c++) begin
      @(negedge clk);
      if (cache_new_data === 1'b1) begin
        n_cmp++;
        if (wr_q.size() == 0) begin
          n_bad++; $display("FAIL all4_strobe: got unexpected strobe din=%0d want none", cache_data_in);
        end else begin
          t = wr_q.pop_front();
          if (cache_data_in !== t.data) begin
            n_bad++; $display("FAIL all4_strobe: got din=%0d want %0d", cache_data_in, t.data);
          end
        end
        if (last_c >= 0) begin
          n_cmp++;
          if (c - last_c != SC + 2) begin
            n_bad++; $display("FAIL all4_spacing: got %0d cycles want %0d", c - last_c, SC + 2);
          end
        end
        last_c = c;
      end
      if (ack !== 4'b0) begin
        n_cmp++;
        if (ack_q.size() == 0) begin
          n_bad++; $display("FAIL all4_ack: got unexpected ack=%b want 0000", ack);
        end else begin
          t = ack_q.pop_front();
          if (ack !== (4'b1 << t.idx) || ack_hit !== t.hit || prev_ack !== 4'b0) begin
            n_bad++;
            $display("FAIL all4_ack: got ack=%b hit=%b prev=%b want ack=%b hit=%b prev=0000",
                     ack, ack_hit, prev_ack, 4'b1 << t.idx, t.hit);
          end
          req[t.idx] = 1'b0;
        end
      end
      prev_ack = ack;
    end
    n_cmp++;
    if (wr_q.size() != 0 || ack_q.size() != 0) begin
      n_bad++; $display("FAIL all4_timeout: got %0d pending want 0", ack_q.size());
    end
    wr_q.delete(); ack_q.delete();
    req = '0;
  endtask

  task automatic test_fairness();
    txn_t t;
    do_reset();
    req_data         = '0;
    req_data[7:0]    = 8'h11;
    req_data[23:16]  = 8'h33;
    push_txn(0, 8'h11, 1'b0);
    push_txn(2, 8'h33, 1'b0);
    push_txn(0, 8'h11, 1'b0);
    push_txn(2, 8'h33, 1'b0);
    req = 4'b0001;
    for (int c = 0; c < 80 && (wr_q.size() != 0 || ack_q.size() != 0); c++) begin
      @(negedge clk);
      if (cache_new_data === 1'b1) begin
        n_cmp++;
        if (wr_q.size() == 0) begin
          n_bad++; $display("FAIL rr_strobe: got unexpected strobe din=%0h want none", cache_data_in);
        end else begin
          t = wr_q.pop_front();
          if (cache_data_in !== t.data) begin
            n_bad++; $display("FAIL rr_strobe: got din=%0h want %0h", cache_data_in, t.data);
          end
        end
        req[2] = 1'b1;
      end
      if (ack !== 4'b0) begin
        n_cmp++;
        if (ack_q.size() == 0) begin
          n_bad++; $display("FAIL rr_ack: got unexpected ack=%b want 0000", ack);
        end else begin
          t = ack_q.pop_front();
          if (ack !== (4'b1 << t.idx) || ack_hit !== t.hit) begin
            n_bad++; $display("FAIL rr_ack: got ack=%b hit=%b want ack=%b hit=%b",
                              ack, ack_hit, 4'b1 << t.idx, t.hit);
          end
        end
        if (ack_q.size() == 0) req = '0;
      end
    end
    n_cmp++;
    if (wr_q.size() != 0 || ack_q.size() != 0) begin
      n_bad++; $display("FAIL rr_timeout: got %0d pending want 0", ack_q.size());
    end
    wr_q.delete(); ack_q.delete();
    req = '0;
  endtask

  task automatic test_hit();
    txn_t          t;
    int            idx_tab  [3] = '{1, 3, 2};
    logic [CS-1:0] word_tab [3] = '{8'd5, 8'd7, 8'd0};
    logic          hit_tab  [3] = '{1'b1, 1'b0, 1'b1};
    cache_data_out         = '0;
    cache_data_out[31:24]  = 8'd5;
    req_data               = '0;
    req_data[15:8]         = 8'd5;
    req_data[31:24]        = 8'd7;
    for (int j = 0; j < 3; j++) begin
      push_txn(idx_tab[j], word_tab[j], hit_tab[j]);
      req[idx_tab[j]] = 1'b1;
      for (int c = 0; c < 30 && (wr_q.size() != 0 || ack_q.size() != 0); c++) begin
        @(negedge clk);
        if (cache_new_data === 1'b1) begin
          n_cmp++;
          if (wr_q.size() == 0) begin
            n_bad++; $display("FAIL hit_strobe%0d: got unexpected strobe want none", j);
          end else begin
            t = wr_q.pop_front();
            if (cache_data_in !== t.data) begin
              n_bad++; $display("FAIL hit_strobe%0d: got din=%0d want %0d", j, cache_data_in, t.data);
            end
          end
        end
        if (ack !== 4'b0) begin
          n_cmp++;
          if (ack_q.size() == 0) begin
            n_bad++; $display("FAIL hit_ack%0d: got unexpected ack=%b want 0000", j, ack);
          end else begin
            t = ack_q.pop_front();
            if (ack !== (4'b1 << t.idx) || ack_hit !== t.hit) begin
              n_bad++; $display("FAIL hit_ack%0d: got ack=%b hit=%b want ack=%b hit=%b",
                                j, ack, ack_hit, 4'b1 << t.idx, t.hit);
            end
            req[t.idx] = 1'b0;
          end
        end else begin
          n_cmp++;
          if (ack_hit !== 1'b0) begin
            n_bad++; $display("FAIL hit_idle%0d: got ack_hit=%b with ack=0 want 0", j, ack_hit);
          end
        end
      end
      n_cmp++;
      if (wr_q.size() != 0 || ack_q.size() != 0) begin
        n_bad++; $display("FAIL hit_timeout%0d: got %0d pending want 0", j, ack_q.size());
      end
      wr_q.delete(); ack_q.delete();
    end
    req = '0;
  endtask

  task automatic test_reset_mid();
    txn_t t;
    bit   seen;
    req_data         = '0;
    req_data[23:16]  = 8'h42;
    req_data[31:24]  = 8'h43;
    req              = 4'b0100;
    seen             = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (cache_new_data === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++; $display("FAIL rstmid_strobe: got no strobe want strobe within 10 cycles");
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || ack !== 4'b0) begin
      n_bad++; $display("FAIL rstmid_settle: got busy=%b ack=%b want busy=1 ack=0000", busy, ack);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (ack !== 4'b0 || ack_hit !== 1'b0 || cache_data_in !== 8'd0 ||
        cache_new_data !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_async: got ack=%b hit=%b din=%0h new=%b busy=%b want all 0",
               ack, ack_hit, cache_data_in, cache_new_data, busy);
    end
    req[3] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (ack !== 4'b0 || busy !== 1'b0) begin
        n_bad++; $display("FAIL rstmid_hold%0d: got ack=%b busy=%b want ack=0000 busy=0", c, ack, busy);
      end
    end
    reset = 1'b1;
    push_txn(2, 8'h42, 1'b0);
    push_txn(3, 8'h43, 1'b0);
    for (int c = 0; c < 40 && (wr_q.size() != 0 || ack_q.size() != 0); c++) begin
      @(negedge clk);
      if (cache_new_data === 1'b1) begin
        n_cmp++;
        if (wr_q.size() == 0) begin
          n_bad++; $display("FAIL rstmid_strobe2: got unexpected strobe want none");
        end else begin
          t = wr_q.pop_front();
          if (cache_data_in !== t.data) begin
            n_bad++; $display("FAIL rstmid_strobe2: got din=%0h want %0h", cache_data_in, t.data);
          end
        end
      end
      if (ack !== 4'b0) begin
        n_cmp++;
        if (ack_q.size() == 0) begin
          n_bad++; $display("FAIL rstmid_ack: got unexpected ack=%b want 0000", ack);
        end else begin
          t = ack_q.pop_front();
          if (ack !== (4'b1 << t.idx) || ack_hit !== t.hit) begin
            n_bad++; $display("FAIL rstmid_ack: got ack=%b hit=%b want ack=%b hit=%b",
                              ack, ack_hit, 4'b1 << t.idx, t.hit);
          end
          req[t.idx] = 1'b0;
        end
      end
    end
    n_cmp++;
    if (wr_q.size() != 0 || ack_q.size() != 0) begin
      n_bad++; $display("FAIL rstmid_timeout: got %0d pending want 0", ack_q.size());
    end
    wr_q.delete(); ack_q.delete();
    req = '0;
  endtask

  task automatic test_idle();
    req = '0;
    @(negedge clk);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      n_cmp++;
      if (cache_new_data !== 1'b0 || ack !== 4'b0 || busy !== 1'b0 || cache_data_in !== 8'h43) begin
        n_bad++;
        $display("FAIL idle_cycle%0d: got new=%b ack=%b busy=%b din=%0h want new=0 ack=0000 busy=0 din=43",
                 c, cache_new_data, ack, busy, cache_data_in);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_hit();
    test_reset_mid();
    test_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lu_cache_arbiter.md
Name: lu_cache_arbiter

Overview:
Round-robin arbiter and sequencer that shares the single write port of the LU cache between REQ_COUNT requesters. It grants one requester at a time and drives the cache's data_in/new_data pulse. It then holds off further writes for a fixed settle time so the cache's replacement logic can finish. Each requester gets a one-cycle ack and a hit flag showing whether its value was already present in the cache at grant time.

Parameters:
REQ_COUNT, 4, number of requesters (>=2)
CELL_SIZE, 8, bits per cache cell and per request word
CELL_COUNT, 8, number of cache cells visible on cache_data_out
SETTLE_CYCLES, 2, cycles after the new_data pulse before the next write may issue (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
req  input  REQ_COUNT  per-requester request; held high until that requester's ack
req_data  input  REQ_COUNT*CELL_SIZE  request words; requester i uses bits [i*CELL_SIZE +: CELL_SIZE]; held stable while req[i] is high
ack  output  REQ_COUNT  one-hot, one-cycle completion pulse
ack_hit  output  1  valid only while ack is nonzero; 1 = value was present in the cache at grant
cache_data_out  input  CELL_COUNT*CELL_SIZE  cache contents, flattened packed array, cell k at [k*CELL_SIZE +: CELL_SIZE]
cache_data_in  output  CELL_SIZE  word presented to the cache
cache_new_data  output  1  one-cycle write strobe to the cache
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (reset=0, asynchronous) sets the following:
  - state=IDLE, settle counter=0.
  - last-grant pointer=REQ_COUNT-1, so requester 0 has top priority after reset.
  - ack=0, ack_hit=0, cache_data_in=0, cache_new_data=0, busy=0.
- All outputs are registered.
- FSM states: IDLE, ISSUE, SETTLE.
- IDLE:
  - At a rising edge with any req bit high, grant the first requester found scanning upward (with wrap) from last-grant+1.
  - On that grant edge, latch the following:
    - grant index; last-grant pointer = grant index.
    - cache_data_in = granted word.
    - hit = 1 if the granted word equals any of the CELL_COUNT cells of cache_data_out.
  - Go to ISSUE.
  - With no req high, stay in IDLE.
- ISSUE:
  - Lasts exactly one cycle, with cache_new_data=1 for that cycle only.
  - Next state is SETTLE with counter=0.
- SETTLE:
  - The counter increments each cycle.
  - In the cycle where counter==SETTLE_CYCLES-1, ack[grant]=1 and ack_hit=hit; the next state is IDLE.
- cache_data_in holds the latched word from grant until the next grant; it does not change in ISSUE or SETTLE.
- Latency, with the request sampled at edge E0:
  - cache_new_data is high in the cycle after E0.
  - ack is high SETTLE_CYCLES+1 cycles after E0.
  - Earliest next grant edge is the end of the IDLE cycle that follows ack.
  - Maximum throughput is one write per SETTLE_CYCLES+2 cycles.
- Handshake:
  - The requester samples ack at the rising edge and drops req at that same edge.
  - A requester that keeps req high after ack is treated as a new request; it loses priority to the others by round-robin.
- req changes during ISSUE or SETTLE are ignored; only IDLE samples req.
- The hit comparison has no per-cell valid tracking: reset-cleared cells (0) match a data value of 0.
- Simultaneous requests: exactly one is granted per transaction, and starvation is bounded. A requester waits at most REQ_COUNT-1 transactions.
- Reset during ISSUE or SETTLE:
  - Aborts immediately: no ack is issued and cache_new_data drops at once.
  - A still-pending req is re-arbitrated from index 0 after reset release.

Test Plan:
- Single request, SETTLE_CYCLES=2: req[1]=1 with word 9 sampled at edge E0 -> cache_new_data=1 with cache_data_in=9 only in cycle E0+1; ack=4'b0010 and ack_hit=0 in cycle E0+3; busy high for cycles E0+1..E0+3.
- All four requesting simultaneously after reset with words 1,2,4,5 -> grant order 0,1,2,3; write strobes carry 1,2,4,5 spaced 4 cycles apart; each ack is one-hot and one cycle wide.
- Round-robin fairness:
  - Stimulus: req[0] held high permanently, req[2] raised after the first grant.
  - Required: grants alternate 0,2,0,2 and requester 0 never receives two consecutive grants while req[2] is pending.
- Hit detection:
  - Stimulus: cache_data_out preloaded so cell 3 = 5, then a request for 5, then a request for 7.
  - Required: ack_hit=1 for the request for 5; ack_hit=0 for the request for 7; ack_hit=0 whenever ack=0.
- Reset mid-operation: assert reset low during the SETTLE cycle -> ack never pulses, all outputs 0 asynchronously; after release with req[2] still high, requester 2 is granted and completes normally.
- Idle stability: no requests for 50 cycles -> cache_new_data, ack and busy stay 0, and cache_data_in keeps its last value.
